// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters.
// One frame per grant, watchdog abort on a missing done, idle gap before re-arbitration.
module uart_tx_arbiter #(
    parameter int N_REQ          = 3,
    parameter int DATA_W         = 9,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 16,
    localparam int ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    input  logic                    i_tx_done,
    output logic [ID_W-1:0]         o_grant_id,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t              state_q;
    state_t              next_state;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     grant_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [CNT_W-1:0]    wdog_q;
    logic [CNT_W-1:0]    gap_q;

    logic [DATA_W-1:0]   payload [N_REQ];
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     win_id;
    logic                win_vld;
    logic                grant_go;
    logic                wdog_hit;
    logic                frame_end;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % N_REQ;
        return ID_W'(sum);
    endfunction

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            payload[k] = i_data[k*DATA_W +: DATA_W];
        end
    end

    // Scan downward so the candidate nearest to last_grant+1 is the final one kept
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = wrap_idx(last_q, i);
            if (i_req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign grant_go  = (state_q == IDLE) && win_vld && !i_tx_busy;
    assign wdog_hit  = (wdog_q == WD_LAST);
    assign frame_end = (state_q == WAIT_DONE) && (i_tx_done || wdog_hit);

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done || wdog_hit) begin
                    next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= IDLE;
            last_q    <= ID_W'(N_REQ - 1);
            grant_q   <= '0;
            tx_data_q <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q <= next_state;
            case (state_q)
                IDLE: begin
                    if (grant_go) begin
                        grant_q   <= win_id;
                        tx_data_q <= payload[win_id];
                    end
                end
                START: begin
                    wdog_q <= '0;
                end
                WAIT_DONE: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (frame_end) begin
                        last_q <= grant_q;
                        gap_q  <= '0;
                    end
                end
                GAP: begin
                    gap_q <= gap_q + 1'b1;
                end
                default: begin
                    gap_q <= '0;
                end
            endcase
            if (next_state == IDLE) begin
                tx_data_q <= '0;
            end
        end
    end

    // Pulses are masked during reset so an abort never emits a stray ack or timeout
    assign o_tx_start = (state_q == START) && !i_reset;
    assign o_ack      = o_tx_start ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign o_timeout  = (state_q == WAIT_DONE) && wdog_hit && !i_tx_done && !i_reset;
    assign o_busy     = (state_q != IDLE);
    assign o_grant_id = grant_q;
    assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model (880-cycle frame then done pulse),
// scoreboard of expected grants popped on each o_tx_start.
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 3;
    localparam int DATA_W = 9;
    localparam int FRAME  = 880;
    localparam int GAP    = 16;
    localparam int TMO    = 1024;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                    clk;
    logic                    i_reset;
    logic [N_REQ-1:0]        i_req;
    logic [N_REQ*DATA_W-1:0] i_data;
    logic [N_REQ-1:0]        o_ack;
    logic                    o_tx_start;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    i_tx_busy;
    logic                    i_tx_done;
    logic [1:0]              o_grant_id;
    logic                    o_busy;
    logic                    o_timeout;

    exp_t              exp_q[$];
    int                start_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                n_start = 0;
    int                n_ack = 0;
    int                n_to = 0;
    int                last_start = 0;
    logic [DATA_W-1:0] cur_data = '0;
    logic [DATA_W-1:0] d [4];
    logic              done_en = 1'b1;
    logic              busy_force = 1'b0;

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .o_ack(o_ack), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_tx_busy(i_tx_busy), .i_tx_done(i_tx_done), .o_grant_id(o_grant_id),
        .o_busy(o_busy), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_exp(input int id, input logic [DATA_W-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Transmitter model: busy from the start cycle for FRAME cycles, done pulse after
    initial begin
        int  cnt;
        logic active;
        cnt = 0;
        active = 1'b0;
        i_tx_busy = 1'b0;
        i_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_tx_done = 1'b0;
            if (o_tx_start) begin
                active = 1'b1;
                cnt = FRAME;
            end else if (active) begin
                if (cnt == 0) begin
                    active = 1'b0;
                    i_tx_done = done_en;
                end else begin
                    cnt--;
                end
            end
            i_tx_busy = active | busy_force;
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                n_start++;
                last_start = cyc;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_start", 32'(o_tx_start), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    cur_data = e.data;
                    check_val("grant_id", 32'(o_grant_id), 32'(e.id));
                    check_val("tx_data", 32'(o_tx_data), 32'(e.data));
                    check_val("ack_onehot", 32'(o_ack), 32'(1) << e.id);
                end
            end else if (o_ack != '0) begin
                check_val("ack_outside_start", 32'(o_ack), 32'd0);
            end
            if (o_ack != '0) n_ack++;
            if (o_timeout) n_to++;
            if (i_tx_done && o_busy) check_val("data_stable", 32'(o_tx_data), 32'(cur_data));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic set_req(input logic [N_REQ-1:0] r);
        @(posedge clk); #1;
        i_req = r;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int got;
        int k;
        got = 0;
        k = 0;
        while (got < n && k < budget) begin
            @(negedge clk);
            k++;
            if (o_ack != '0) got++;
        end
        if (got < n) check_val("ack_wait_expired", 32'(got), 32'(n));
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((o_busy || i_tx_busy) && k < budget);
        if (o_busy || i_tx_busy) check_val("idle_wait_expired", 32'(o_busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"},     32'(o_busy), 32'd0);
        check_val({tag, "_start"},    32'(o_tx_start), 32'd0);
        check_val({tag, "_ack"},      32'(o_ack), 32'd0);
        check_val({tag, "_data"},     32'(o_tx_data), 32'd0);
        check_val({tag, "_grant"},    32'(o_grant_id), 32'd0);
        check_val({tag, "_timeout"},  32'(o_timeout), 32'd0);
    endtask

    initial begin
        int s;
        int s0;
        int a0;
        int t0;
        int k;
        d[0] = 9'b100110011;
        d[1] = 9'h0A5;
        d[2] = 9'h15A;
        d[3] = 9'h03C;
        i_reset = 1'b1;
        i_req = '0;
        i_data = {d[2], d[1], d[0]};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        i_reset = 1'b0;

        // 1: single request, busy duration
        do_reset();
        push_exp(0, d[0]);
        set_req(3'b001);
        wait_acks(1, 50);
        s = last_start;
        set_req(3'b000);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (o_busy && k < 1500);
        check_val("t1_busy_len", 32'(cyc - s), 32'(FRAME + GAP + 2));
        check_val("t1_data_cleared", 32'(o_tx_data), 32'd0);
        wait_idle(100);

        // 2: all requesting, round-robin order and spacing; req0 payload changes after ack
        do_reset();
        start_q.delete();
        s0 = n_start;
        push_exp(0, d[0]);
        push_exp(1, d[1]);
        push_exp(2, d[2]);
        push_exp(0, d[3]);
        set_req(3'b111);
        wait_acks(1, 50);
        @(posedge clk); #1;
        i_data[0 +: DATA_W] = d[3];
        wait_acks(3, 4000);
        set_req(3'b000);
        wait_idle(1500);
        check_val("t2_starts", 32'(n_start - s0), 32'd4);
        for (int i = 1; i < start_q.size(); i++) begin
            check_val("t2_spacing", 32'(start_q[i] - start_q[i-1]), 32'(FRAME + 1 + GAP + 2));
        end
        i_data = {d[2], d[1], d[0]};

        // 3: fairness, req0 held, req1 pulsed
        do_reset();
        s0 = n_start;
        push_exp(0, d[0]);
        push_exp(1, d[1]);
        push_exp(0, d[0]);
        set_req(3'b001);
        wait_acks(1, 50);
        set_req(3'b011);
        wait_acks(1, 1500);
        set_req(3'b001);
        wait_acks(1, 1500);
        set_req(3'b000);
        wait_idle(1500);
        check_val("t3_starts", 32'(n_start - s0), 32'd3);

        // 4: watchdog abort, pointer advances to requester 1
        do_reset();
        t0 = n_to;
        @(negedge clk);
        done_en = 1'b0;
        push_exp(0, d[0]);
        push_exp(1, d[1]);
        set_req(3'b011);
        wait_acks(1, 50);
        s = last_start;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_timeout && k < 1200);
        check_val("t4_timeout_lat", 32'(cyc - s), 32'(TMO));
        done_en = 1'b1;
        wait_acks(1, 200);
        check_val("t4_regrant_lat", 32'(last_start - s), 32'(TMO + GAP + 2));
        set_req(3'b000);
        wait_idle(1500);
        check_val("t4_timeouts", 32'(n_to - t0), 32'd1);

        // 5: transmitter busy blocks grant
        do_reset();
        s0 = n_start;
        a0 = n_ack;
        @(negedge clk);
        busy_force = 1'b1;
        push_exp(1, d[1]);
        set_req(3'b010);
        repeat (20) @(negedge clk);
        check_val("t5_no_start", 32'(n_start - s0), 32'd0);
        check_val("t5_no_ack", 32'(n_ack - a0), 32'd0);
        busy_force = 1'b0;
        s = cyc + 1;
        wait_acks(1, 50);
        check_val("t5_start_lat", 32'(last_start - s), 32'd1);
        set_req(3'b000);
        wait_idle(1500);

        // 6: reset in the middle of a frame
        do_reset();
        t0 = n_to;
        push_exp(0, d[0]);
        set_req(3'b001);
        wait_acks(1, 50);
        s = last_start;
        set_req(3'b000);
        while (cyc != s + 401) begin
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        i_req = 3'b011;
        push_exp(0, d[0]);
        @(negedge clk);
        check_outputs_zero("t6_after_reset");
        wait_acks(1, 1000);
        check_val("t6_regrant_at_done", 32'(last_start - s), 32'(FRAME + 2));
        set_req(3'b000);
        wait_idle(1500);
        check_val("t6_no_timeout", 32'(n_to - t0), 32'd0);

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
